reg_scoreboard_fwd: RTL and testbench

Parametrised register-hazard unit that generalises the pipeline's fixed three-stage dest-compare stall into a per-register scoreboard with result forwarding.
It sits beside the decode stage of the in-order pipeline.
It tracks, per architectural register, how many in-flight producers exist and whether the newest value has been computed.
Decode stalls only when a source value is truly unavailable (e.g. load-use); otherwise it receives the forwarded operand.

---
 rtl/reg_scoreboard_fwd.sv | 102 ++++++++++
 tb/tb_reg_scoreboard_fwd.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard_fwd.sv
// Per-register hazard scoreboard beside decode: counts in-flight producers per
// architectural register, forwards produced-but-not-written values, stalls otherwise.
module reg_scoreboard_fwd #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_PEND = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          iss_valid,
  input  logic          iss_rs1_en,
  input  logic [AW-1:0] iss_rs1,
  input  logic          iss_rs2_en,
  input  logic [AW-1:0] iss_rs2,
  input  logic          iss_rd_en,
  input  logic [AW-1:0] iss_rd,
  output logic          stall,
  output logic          rs1_fwd,
  output logic [DW-1:0] rs1_data,
  output logic          rs2_fwd,
  output logic [DW-1:0] rs2_data,
  input  logic          res_valid,
  input  logic [AW-1:0] res_rd,
  input  logic [DW-1:0] res_data,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd
);

  localparam int NREG = 1 << AW;
  localparam int CW   = 3;

  logic [CW-1:0] pend_res [NREG];
  logic [CW-1:0] pend_wb  [NREG];
  logic [DW-1:0] val      [NREG];

  logic          hz1, hz2, f1, f2, rd_full, issue_fire;
  logic [DW-1:0] d1, d2;

  // Netted counter step; decrement of an empty counter holds at zero.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                             input logic inc, input logic dec);
    if (inc && !dec)      return c + 3'd1;
    else if (dec && !inc) return (c == '0) ? '0 : c - 3'd1;
    else                  return c;
  endfunction

  // Returns {hazard, fwd, data} for one source operand.
  function automatic logic [DW+1:0] lookup(input logic en, input logic [AW-1:0] a,
                                           input logic [CW-1:0] pr, input logic [CW-1:0] pw,
                                           input logic [DW-1:0] v, input logic rv,
                                           input logic [AW-1:0] rrd, input logic [DW-1:0] rdat);
    if (!en || a == '0 || pw == '0) return {2'b00, {DW{1'b0}}};
    else if (pr == '0)              return {2'b01, v};
    else if (pr == 3'd1 && rv && rrd == a) return {2'b01, rdat};
    else                            return {2'b10, {DW{1'b0}}};
  endfunction

  always_comb begin
    {hz1, f1, d1} = lookup(iss_rs1_en, iss_rs1, pend_res[iss_rs1], pend_wb[iss_rs1],
                           val[iss_rs1], res_valid, res_rd, res_data);
    {hz2, f2, d2} = lookup(iss_rs2_en, iss_rs2, pend_res[iss_rs2], pend_wb[iss_rs2],
                           val[iss_rs2], res_valid, res_rd, res_data);
    // A same-cycle writeback to rd frees a slot, so a full rd does not block.
    rd_full    = iss_rd_en && (iss_rd != '0) && (pend_wb[iss_rd] == CW'(MAX_PEND))
                 && !(wb_valid && wb_rd == iss_rd);
    stall      = iss_valid && (hz1 || hz2 || rd_full);
    issue_fire = iss_valid && !stall;
    rs1_fwd    = iss_valid && f1;
    rs2_fwd    = iss_valid && f2;
    rs1_data   = (iss_valid && f1) ? d1 : '0;
    rs2_data   = (iss_valid && f2) ? d2 : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        pend_res[r] <= '0;
        pend_wb[r]  <= '0;
        val[r]      <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        pend_res[r] <= cnt_next(pend_res[r],
                                issue_fire && iss_rd_en && iss_rd == AW'(r),
                                res_valid && res_rd == AW'(r));
        pend_wb[r]  <= cnt_next(pend_wb[r],
                                issue_fire && iss_rd_en && iss_rd == AW'(r),
                                wb_valid && wb_rd == AW'(r));
        if (res_valid && res_rd == AW'(r)) val[r] <= res_data;
      end
    end
  end

  // Results or writebacks for a register with nothing outstanding are illegal.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (res_valid && res_rd != '0) assert (pend_res[res_rd] != '0);
      if (wb_valid && wb_rd != '0)   assert (pend_wb[wb_rd] != '0);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard_fwd.sv
// Bench for reg_scoreboard_fwd: directed scenarios plus random legal traffic
// compared against a per-register in-flight-producer queue model.
module tb_reg_scoreboard_fwd;
  localparam int AW = 5, DW = 32, MAXP = 3, NREG = 32;

  logic          clk = 1'b0, resetn;
  logic          iss_valid, iss_rs1_en, iss_rs2_en, iss_rd_en;
  logic [AW-1:0] iss_rs1, iss_rs2, iss_rd, res_rd, wb_rd;
  logic          stall, rs1_fwd, rs2_fwd, res_valid, wb_valid;
  logic [DW-1:0] rs1_data, rs2_data, res_data;

  int n_checks = 0, n_fails = 0;

  // Model: each register holds a FIFO of in-flight producers (1 = result produced).
  bit            prod_q [NREG][$];
  logic [DW-1:0] val_m  [NREG];

  always #5 clk = ~clk;

  reg_scoreboard_fwd #(.AW(AW), .DW(DW), .MAX_PEND(MAXP)) dut (
    .clk(clk), .resetn(resetn), .iss_valid(iss_valid),
    .iss_rs1_en(iss_rs1_en), .iss_rs1(iss_rs1), .iss_rs2_en(iss_rs2_en), .iss_rs2(iss_rs2),
    .iss_rd_en(iss_rd_en), .iss_rd(iss_rd), .stall(stall),
    .rs1_fwd(rs1_fwd), .rs1_data(rs1_data), .rs2_fwd(rs2_fwd), .rs2_data(rs2_data),
    .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd));

  function automatic void lookup_m(input logic en, input logic [AW-1:0] a,
                                   output logic fwd, output logic [DW-1:0] d, output logic haz);
    int unp;
    fwd = 0; d = '0; haz = 0; unp = 0;
    if (!en || a == 0 || prod_q[a].size() == 0) return;
    for (int i = 0; i < prod_q[a].size(); i++) if (!prod_q[a][i]) unp++;
    if (unp == 0) begin fwd = 1; d = val_m[a]; end
    else if (unp == 1 && res_valid && res_rd == a) begin fwd = 1; d = res_data; end
    else haz = 1;
  endfunction

  function automatic void expect_m(output logic st, output logic f1, output logic [DW-1:0] d1,
                                   output logic f2, output logic [DW-1:0] d2);
    logic h1, h2, full;
    lookup_m(iss_rs1_en, iss_rs1, f1, d1, h1);
    lookup_m(iss_rs2_en, iss_rs2, f2, d2, h2);
    full = iss_rd_en && iss_rd != 0 && prod_q[iss_rd].size() == MAXP && !(wb_valid && wb_rd == iss_rd);
    st = iss_valid && (h1 || h2 || full);
    if (!iss_valid) begin f1 = 0; f2 = 0; end
  endfunction

  task automatic model_update();
    logic st, f1, f2; logic [DW-1:0] d1, d2;
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin prod_q[r].delete(); val_m[r] = '0; end
    end else begin
      expect_m(st, f1, d1, f2, d2);
      if (res_valid && res_rd != 0) begin
        for (int i = 0; i < prod_q[res_rd].size(); i++)
          if (!prod_q[res_rd][i]) begin prod_q[res_rd][i] = 1'b1; break; end
        val_m[res_rd] = res_data;
      end
      if (wb_valid && wb_rd != 0) void'(prod_q[wb_rd].pop_front());
      if (iss_valid && !st && iss_rd_en && iss_rd != 0) prod_q[iss_rd].push_back(1'b0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_rs1_en = 0; iss_rs2_en = 0; iss_rd_en = 0;
    iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    res_valid = 0; res_rd = '0; res_data = '0; wb_valid = 0; wb_rd = '0;
  endtask

  task automatic issue(input logic r1en, input logic [AW-1:0] r1, input logic r2en,
                       input logic [AW-1:0] r2, input logic rden, input logic [AW-1:0] rd);
    iss_valid = 1; iss_rs1_en = r1en; iss_rs1 = r1; iss_rs2_en = r2en; iss_rs2 = r2;
    iss_rd_en = rden; iss_rd = rd;
  endtask

  task automatic test_reset();
    idle(); resetn = 0; tick(); tick();
    issue(1, 5'd3, 1, 5'd4, 1, 5'd3); #2;
    n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL reset_stall got %b want 0", stall); end
    n_checks++; if (rs1_fwd !== 1'b0 || rs2_fwd !== 1'b0) begin n_fails++; $display("FAIL reset_fwd got %b%b want 00", rs1_fwd, rs2_fwd); end
    n_checks++; if (rs1_data !== '0) begin n_fails++; $display("FAIL reset_data got %h want 0", rs1_data); end
    tick(); resetn = 1;
    idle(); issue(1, 5'd5, 0, 5'd0, 0, 5'd0); #2;
    n_checks++; if (stall !== 1'b0 || rs1_fwd !== 1'b0) begin n_fails++; $display("FAIL no_producer got stall=%b fwd=%b want 0 0", stall, rs1_fwd); end
    tick();
  endtask

  task automatic test_forward();
    idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd3); #2;
    n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL fwd_issue stall got %b want 0", stall); end
    tick();
    idle(); issue(1, 5'd3, 0, 5'd0, 0, 5'd0); res_valid = 1; res_rd = 5'd3; res_data = 32'h1234; #2;
    n_checks++; if (stall !== 1'b0 || rs1_fwd !== 1'b1 || rs1_data !== 32'h1234)
      begin n_fails++; $display("FAIL bypass got stall=%b fwd=%b data=%h want 0 1 1234", stall, rs1_fwd, rs1_data); end
    tick();
    res_valid = 0; #2;
    n_checks++; if (rs1_fwd !== 1'b1 || rs1_data !== 32'h1234)
      begin n_fails++; $display("FAIL fwd_val got fwd=%b data=%h want 1 1234", rs1_fwd, rs1_data); end
    tick();
    wb_valid = 1; wb_rd = 5'd3; #2;
    n_checks++; if (rs1_fwd !== 1'b1 || rs1_data !== 32'h1234)
      begin n_fails++; $display("FAIL fwd_during_wb got fwd=%b data=%h want 1 1234", rs1_fwd, rs1_data); end
    tick();
    wb_valid = 0; #2;
    n_checks++; if (rs1_fwd !== 1'b0 || stall !== 1'b0) begin n_fails++; $display("FAIL after_wb got fwd=%b stall=%b want 0 0", rs1_fwd, stall); end
    tick();
  endtask

  task automatic test_load_use();
    idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd7); tick();
    idle(); issue(0, 5'd0, 1, 5'd7, 0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      #2; n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL load_use_hold%0d stall got %b want 1", k, stall); end
      tick();
    end
    res_valid = 1; res_rd = 5'd7; res_data = 32'hDEAD; #2;
    n_checks++; if (stall !== 1'b0 || rs2_fwd !== 1'b1 || rs2_data !== 32'hDEAD)
      begin n_fails++; $display("FAIL load_use_release got stall=%b fwd=%b data=%h want 0 1 dead", stall, rs2_fwd, rs2_data); end
    tick();
    idle(); wb_valid = 1; wb_rd = 5'd7; tick();
  endtask

  task automatic test_multi_producer();
    idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd4); tick(); tick();
    idle(); res_valid = 1; res_rd = 5'd4; res_data = 32'h1; tick();
    idle(); issue(1, 5'd4, 0, 5'd0, 0, 5'd0); #2;
    n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL two_prod_one_res stall got %b want 1", stall); end
    tick();
    idle(); res_valid = 1; res_rd = 5'd4; res_data = 32'h2; tick();
    idle(); issue(1, 5'd4, 0, 5'd0, 0, 5'd0); #2;
    n_checks++; if (stall !== 1'b0 || rs1_fwd !== 1'b1 || rs1_data !== 32'h2)
      begin n_fails++; $display("FAIL two_prod_newest got stall=%b fwd=%b data=%h want 0 1 2", stall, rs1_fwd, rs1_data); end
    tick();
    idle(); wb_valid = 1; wb_rd = 5'd4; tick(); tick();
    idle(); issue(1, 5'd4, 0, 5'd0, 0, 5'd0); #2;
    n_checks++; if (rs1_fwd !== 1'b0 || stall !== 1'b0) begin n_fails++; $display("FAIL two_prod_drained got fwd=%b stall=%b want 0 0", rs1_fwd, stall); end
    tick();
  endtask

  task automatic test_rd_full();
    idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd9); tick(); tick(); tick();
    idle(); res_valid = 1; res_rd = 5'd9; res_data = 32'hAA; tick();
    idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd9); #2;
    n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL rd_full stall got %b want 1", stall); end
    tick();
    wb_valid = 1; wb_rd = 5'd9; #2;
    n_checks++; if (stall !== 1'b0) begin n_fails++; $display("FAIL rd_full_wb stall got %b want 0", stall); end
    tick();
    wb_valid = 0; #2;
    n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL rd_full_again stall got %b want 1", stall); end
    tick();
    for (int k = 0; k < 3; k++) begin idle(); res_valid = 1; res_rd = 5'd9; res_data = 32'hB0 + k; tick(); end
    for (int k = 0; k < 3; k++) begin idle(); wb_valid = 1; wb_rd = 5'd9; tick(); end
    idle(); issue(1, 5'd9, 0, 5'd0, 1, 5'd9); #2;
    n_checks++; if (stall !== 1'b0 || rs1_fwd !== 1'b0) begin n_fails++; $display("FAIL rd_full_drained got stall=%b fwd=%b want 0 0", stall, rs1_fwd); end
    tick();
    idle(); res_valid = 1; res_rd = 5'd9; res_data = 32'hC; tick();
    idle(); wb_valid = 1; wb_rd = 5'd9; tick();
  endtask

  task automatic test_reg0();
    for (int k = 0; k < 2; k++) begin
      idle(); issue(1, 5'd0, 1, 5'd0, 1, 5'd0); #2;
      n_checks++; if (stall !== 1'b0 || rs1_fwd !== 1'b0 || rs2_fwd !== 1'b0)
        begin n_fails++; $display("FAIL reg0_%0d got stall=%b fwd=%b%b want 0 00", k, stall, rs1_fwd, rs2_fwd); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle(); issue(0, 5'd0, 0, 5'd0, 1, 5'd6); tick(); tick();
    idle(); issue(1, 5'd6, 0, 5'd0, 0, 5'd0); #2;
    n_checks++; if (stall !== 1'b1) begin n_fails++; $display("FAIL mid_pending stall got %b want 1", stall); end
    resetn = 0; tick(); resetn = 1; #2;
    n_checks++; if (stall !== 1'b0 || rs1_fwd !== 1'b0) begin n_fails++; $display("FAIL mid_reset got stall=%b fwd=%b want 0 0", stall, rs1_fwd); end
    tick();
  endtask

  task automatic test_random();
    logic st, f1, f2; logic [DW-1:0] d1, d2;
    int cand[$];
    for (int c = 0; c < 600; c++) begin
      idle();
      cand.delete();
      for (int r = 1; r < 8; r++)
        for (int i = 0; i < prod_q[r].size(); i++) if (!prod_q[r][i]) begin cand.push_back(r); break; end
      if (cand.size() > 0 && $urandom_range(1, 0) == 1) begin
        res_valid = 1; res_rd = AW'(cand[$urandom_range(cand.size() - 1, 0)]); res_data = $urandom;
      end
      cand.delete();
      for (int r = 1; r < 8; r++) if (prod_q[r].size() > 0 && prod_q[r][0]) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(2, 0) == 0) begin
        wb_valid = 1; wb_rd = AW'(cand[$urandom_range(cand.size() - 1, 0)]);
      end
      iss_valid = ($urandom_range(3, 0) != 0);
      iss_rs1_en = $urandom_range(1, 0); iss_rs1 = AW'($urandom_range(7, 0));
      iss_rs2_en = $urandom_range(1, 0); iss_rs2 = AW'($urandom_range(7, 0));
      iss_rd_en = $urandom_range(1, 0);  iss_rd = AW'($urandom_range(7, 0));
      #2;
      expect_m(st, f1, d1, f2, d2);
      n_checks++; if (stall !== st) begin n_fails++; $display("FAIL rnd%0d_stall got %b want %b", c, stall, st); end
      n_checks++; if (rs1_fwd !== f1 || (f1 && rs1_data !== d1))
        begin n_fails++; $display("FAIL rnd%0d_rs1 got %b/%h want %b/%h", c, rs1_fwd, rs1_data, f1, d1); end
      n_checks++; if (rs2_fwd !== f2 || (f2 && rs2_data !== d2))
        begin n_fails++; $display("FAIL rnd%0d_rs2 got %b/%h want %b/%h", c, rs2_fwd, rs2_data, f2, d2); end
      tick();
    end
  endtask

  initial begin
    idle(); resetn = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_multi_producer();
    test_rd_full();
    test_reg0();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
